// File: rtl/cnt27_down_if.sv
// Control/status bundle for the cnt27_down interval timer: the master drives
// enable, load, start, stop and the reload value; the timer returns out, tc and busy.
interface cnt27_down_if #(
    parameter int WIDTH = 27,
    parameter int OUTW  = 4
);
    logic             ena0;
    logic             load;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] din;
    logic [OUTW-1:0]  out;
    logic             tc;
    logic             busy;

    modport master (
        output ena0, load, start, stop, din,
        input  out, tc, busy
    );

    modport slave (
        input  ena0, load, start, stop, din,
        output out, tc, busy
    );
endinterface

// File: rtl/cnt27_down.sv
// Programmable down-counting interval timer with a one-cycle terminal-count pulse.
// Optional: define CNT27_DOWN_AUTORELOAD_EN to restart from the reload value after DONE.
module cnt27_down #(
    parameter int WIDTH = 27,
    parameter int OUTW  = 4
) (
    input  logic        clkin,
    input  logic        rst0,
    cnt27_down_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] rld_reg;
    logic [OUTW-1:0]  out_reg;
    logic [OUTW-1:0]  tap;
    logic [WIDTH-1:0] start_value;
    logic             cnt_last;

    // Display tap: the top OUTW bits of the live count.
    for (genvar gi = 0; gi < OUTW; gi++) begin : g_tap
        assign tap[gi] = cnt_reg[WIDTH-OUTW+gi];
    end

    // A load coinciding with start must take effect on this countdown.
    assign start_value = bus.load ? bus.din : rld_reg;
    assign cnt_last    = (cnt_reg <= WIDTH'(1));

    always_ff @(posedge clkin or negedge rst0) begin
        if (!rst0) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rld_reg   <= '0;
            out_reg   <= '0;
        end else begin
            out_reg <= tap;
            if (bus.load) begin
                rld_reg <= bus.din;
            end
            case (state_reg)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        cnt_reg   <= start_value;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_reg <= IDLE;
                    end else if (bus.ena0) begin
                        if (cnt_last) begin
                            cnt_reg   <= '0;
                            state_reg <= DONE;
                        end else begin
                            cnt_reg <= cnt_reg - WIDTH'(1);
                        end
                    end
                end
                DONE: begin
`ifdef CNT27_DOWN_AUTORELOAD_EN
                    if (bus.stop) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg   <= rld_reg;
                        state_reg <= RUN;
                    end
`else
                    state_reg <= IDLE;
`endif
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.out  = out_reg;
    assign bus.tc   = (state_reg == DONE);
    assign bus.busy = (state_reg == RUN);
endmodule

// File: tb/tb_cnt27_down.sv
// Self-checking bench for cnt27_down: directed scenarios plus randomized
// traffic against a behavioural timer model.
module tb_cnt27_down;
    localparam int W  = 27;
    localparam int OW = 4;

    logic clkin = 1'b0;
    logic rst0  = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    cnt27_down_if #(.WIDTH(W), .OUTW(OW)) bus ();

    cnt27_down #(.WIDTH(W), .OUTW(OW)) dut (
        .clkin (clkin),
        .rst0  (rst0),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    // Behavioural model: a mode word and plain integer count arithmetic.
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
    int          m_mode;
    longint      m_cnt;
    longint      m_rld;
    longint      m_out;
    localparam longint MAXV = (64'd1 << W) - 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_cnt  = 0;
        m_rld  = 0;
        m_out  = 0;
    endtask

    task automatic model_step();
        longint old_rld;
        old_rld = m_rld;
        m_out   = m_cnt / (64'd1 << (W - OW));
        if (bus.load) m_rld = longint'(bus.din);
        if (m_mode == M_IDLE) begin
            if (bus.start && !bus.stop) begin
                m_cnt  = bus.load ? longint'(bus.din) : old_rld;
                m_mode = M_RUN;
            end
        end else if (m_mode == M_RUN) begin
            if (bus.stop) m_mode = M_IDLE;
            else if (bus.ena0) begin
                if (m_cnt <= 1) begin
                    m_cnt  = 0;
                    m_mode = M_DONE;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end else begin
`ifdef CNT27_DOWN_AUTORELOAD_EN
            if (bus.stop) m_mode = M_IDLE;
            else begin
                m_cnt  = old_rld;
                m_mode = M_RUN;
            end
`else
            m_mode = M_IDLE;
`endif
        end
    endtask

    task automatic compare_all();
        check("tc",   64'(bus.tc),   64'(m_mode == M_DONE));
        check("busy", 64'(bus.busy), 64'(m_mode == M_RUN));
        check("out",  64'(bus.out),  64'(m_out));
        check("cnt",  64'(dut.cnt_reg), 64'(m_cnt));
    endtask

    task automatic drive(input logic l, input logic s, input logic p, input logic e,
                         input logic [W-1:0] d);
        bus.load  = l;
        bus.start = s;
        bus.stop  = p;
        bus.ena0  = e;
        bus.din   = d;
    endtask

    task automatic tick();
        @(posedge clkin);
        model_step();
        @(negedge clkin);
        compare_all();
    endtask

    // Asserts reset between edges and checks that it acts without a clock.
    task automatic async_reset();
        #2;
        rst0 = 1'b0;
        model_reset();
        #1;
        check("rst_cnt",  64'(dut.cnt_reg), 64'd0);
        check("rst_out",  64'(bus.out),  64'd0);
        check("rst_tc",   64'(bus.tc),   64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clkin);
        rst0 = 1'b1;
    endtask

    // Starts a countdown from rld with an optional ena0 gap; reports the tc edge.
    task automatic run_count(input int gap_at, input int gap_len,
                             output int tc_edge, output int tc_cnt, output int busy_cnt);
        tc_edge = -1; tc_cnt = 0; busy_cnt = 0;
        drive(0, 1, 0, 1, '0);
        tick();
        busy_cnt += int'(bus.busy);
        drive(0, 0, 0, 1, '0);
        for (int k = 1; k <= 20; k++) begin
            bus.ena0 = !(k >= gap_at && k < gap_at + gap_len);
            tick();
            if (bus.tc) begin
                tc_cnt++;
                if (tc_edge < 0) tc_edge = k;
            end
            busy_cnt += int'(bus.busy);
            if (k >= gap_at && k < gap_at + gap_len)
                check("gap_hold", 64'(dut.cnt_reg), 64'(5 - (gap_at - 1)));
            if (tc_edge > 0 && k > tc_edge + 1) break;
        end
        drive(0, 0, 0, 0, '0);
    endtask

    int tc_edge, tc_cnt, busy_cnt, tc_seen;

    initial begin
        drive(0, 0, 0, 0, '0);
        model_reset();
        #1;
        compare_all();
        @(negedge clkin);
        rst0 = 1'b1;

        // Load 5, start next cycle, continuous enable.
        drive(1, 0, 0, 0, W'(5));
        tick();
        run_count(100, 0, tc_edge, tc_cnt, busy_cnt);
        check("t1_tc_edge", 64'(tc_edge), 64'd5);
        check("t1_tc_cnt",  64'(tc_cnt),  64'd1);
        check("t1_busy",    64'(busy_cnt), 64'd5);
        $display("txn basic5: tc_edge=%0d busy=%0d", tc_edge, busy_cnt);

        // Same count with a 3-cycle enable gap.
        run_count(3, 3, tc_edge, tc_cnt, busy_cnt);
        check("t2_tc_edge", 64'(tc_edge), 64'd8);
        check("t2_tc_cnt",  64'(tc_cnt),  64'd1);
        check("t2_busy",    64'(busy_cnt), 64'd8);
        $display("txn gap3: tc_edge=%0d busy=%0d", tc_edge, busy_cnt);

        // Load+start at full scale; a load in RUN leaves cnt alone.
        drive(1, 1, 0, 0, W'(MAXV));
        tick();
        check("t3_cnt_max", 64'(dut.cnt_reg), 64'(MAXV));
        drive(1, 0, 0, 0, W'(3));
        tick();
        check("t3_out_f",   64'(bus.out), 64'hF);
        check("t3_cnt_keep", 64'(dut.cnt_reg), 64'(MAXV));
        drive(0, 0, 1, 0, '0);
        tick();
        $display("txn fullscale: cnt=%0h out=%0h", dut.cnt_reg, bus.out);

        // Reset at cnt=2, then start loads the cleared reload value.
        drive(1, 1, 0, 1, W'(5));
        tick();
        drive(0, 0, 0, 1, '0);
        for (int k = 0; k < 3; k++) tick();
        check("t4_cnt2", 64'(dut.cnt_reg), 64'd2);
        async_reset();
        drive(0, 1, 0, 0, '0);
        tick();
        check("t4_zero_start", 64'(dut.cnt_reg), 64'd0);
        check("t4_busy", 64'(bus.busy), 64'd1);
        drive(0, 0, 0, 1, '0);
        tick();
        check("t4_zero_tc", 64'(bus.tc), 64'd1);
        drive(0, 0, 1, 0, '0);
        tick();
        $display("txn reset_mid: done");

        // Stop at cnt=4, no tc, later start reloads 6.
        drive(1, 1, 0, 0, W'(6));
        tick();
        drive(0, 0, 0, 1, '0);
        tick();
        tick();
        drive(0, 1, 1, 1, '0);
        tick();
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_cnt4", 64'(dut.cnt_reg), 64'd4);
        tc_seen = 0;
        drive(0, 0, 0, 1, '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            tc_seen += int'(bus.tc);
        end
        check("t5_no_tc", 64'(tc_seen), 64'd0);
        drive(0, 1, 0, 0, '0);
        tick();
        check("t5_reload", 64'(dut.cnt_reg), 64'd6);
        drive(0, 0, 1, 0, '0);
        tick();
        $display("txn stop4: done");

`ifdef CNT27_DOWN_AUTORELOAD_EN
        // Auto-reload with rld=2: tc on edges 2, 5, 8; stop in DONE idles.
        drive(1, 1, 0, 1, W'(2));
        tick();
        drive(0, 0, 0, 1, '0);
        tc_seen = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (bus.tc) tc_seen++;
            check("t6_tc_period", 64'(bus.tc), 64'(k % 3 == 2));
        end
        check("t6_tc_count", 64'(tc_seen), 64'd3);
        bus.stop = 1'b1;
        tick();
        check("t6_stop_idle", 64'(bus.busy), 64'd0);
        drive(0, 0, 0, 0, '0);
        tick();
        $display("txn autoreload: pulses=%0d", tc_seen);
`endif

        // Randomized traffic checked every cycle against the model.
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 500; i++) begin
                drive($urandom_range(0, 7) == 0,
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 15) == 0,
                      $urandom_range(0, 3) != 0,
                      ($urandom_range(0, 15) == 0) ? W'($urandom) : W'($urandom_range(0, 12)));
                tick();
                if ($urandom_range(0, 399) == 0) async_reset();
            end
            $display("txn random_block %0d: checks=%0d", blk, checks);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
